// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that launches queued bytes into uart_tx using tx_busy as back-pressure
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;
    state_t state, state_d;
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic push, pop;
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign pop   = state == IDLE && !empty && !tx_busy && !flush;
    assign push  = wr_en && !full && !flush;
    always_comb begin
        state_d = state;
        state_d = state == IDLE      ? (pop ? WAIT_BUSY : IDLE) :
                  state == WAIT_BUSY ? (tx_busy ? WAIT_DONE : WAIT_BUSY) :
                                       (tx_busy ? WAIT_DONE : IDLE);
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_d;
            tx_start <= pop;
            overflow <= wr_en && full && !flush;
            if (pop) tx_data <= mem[rd_ptr];
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: vector table plus scoreboarded corner sequences against a tx_busy stub
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       flush = 1'b0;
    logic       full, empty, overflow, tx_start, tx_busy;
    logic [4:0] count;
    logic [7:0] tx_data;
    logic       auto_busy = 1'b0;
    logic       man_busy = 1'b0;
    logic       stub_busy;
    int         stub_cnt;
    int         total = 0;
    int         bad = 0;
    int         n_start = 0;
    int         n0;
    logic [7:0] sb[$];

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       fl;
        logic       bz;
        int         cnt;
        logic       emp;
        logic       ful;
        logic       ovf;
        logic       st;
    } vec_t;
    vec_t vec [12];

    uart_tx_fifo #(.DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    // uart_tx stand-in: busy rises two cycles after the launch pulse and lasts 8 cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) stub_cnt <= 0;
        else if (tx_start) stub_cnt <= 10;
        else if (stub_cnt != 0) stub_cnt <= stub_cnt - 1;
    end
    assign stub_busy = stub_cnt != 0 && stub_cnt <= 8;
    assign tx_busy = auto_busy ? stub_busy : man_busy;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && tx_start) begin
            n_start++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_start: got tx_data %0h expected no launch at %0t", tx_data, $time);
            end else begin
                chk("tx_data", tx_data, sb.pop_front());
            end
        end
    end

    task automatic step(input logic w, input logic [7:0] d, input logic f, input logic b);
        wr_en = w;
        wr_data = d;
        flush = f;
        man_busy = b;
        @(negedge clk);
    endtask

    task automatic wait_busy(input logic lvl, input string nm);
        for (int i = 0; i < 200 && tx_busy !== lvl; i++) @(negedge clk);
        chk(nm, tx_busy, lvl);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 600 && sb.size() != 0; i++) @(negedge clk);
        repeat (12) @(negedge clk);
        chk(nm, sb.size(), 0);
    endtask

    initial begin
        vec[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1};
        vec[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[3]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[4]  = '{1'b1, 8'h02, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[6]  = '{1'b1, 8'h03, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[10] = '{1'b1, 8'h55, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            if (vec[i].fl) sb.delete();
            if (vec[i].wr && !vec[i].fl && !vec[i].ovf) sb.push_back(vec[i].d);
            step(vec[i].wr, vec[i].d, vec[i].fl, vec[i].bz);
            chk($sformatf("v%0d_count", i), count, vec[i].cnt);
            chk($sformatf("v%0d_empty", i), empty, vec[i].emp);
            chk($sformatf("v%0d_full", i), full, vec[i].ful);
            chk($sformatf("v%0d_overflow", i), overflow, vec[i].ovf);
            chk($sformatf("v%0d_tx_start", i), tx_start, vec[i].st);
        end

        for (int i = 0; i < 16; i++) begin
            sb.push_back(8'h10 + 8'(i));
            step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b1);
            chk("fill_full", full, i == 15);
        end
        chk("fill_count", count, 16);
        step(1'b1, 8'h20, 1'b0, 1'b1);
        chk("drop_overflow", overflow, 1);
        chk("drop_count", count, 16);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("overflow_one_cycle", overflow, 0);

        n0 = n_start;
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("popfull_overflow", overflow, 1);
        chk("popfull_count", count, 15);
        chk("popfull_tx_start", tx_start, 1);
        auto_busy = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        drain("wrap_drain");
        chk("wrap_launches", n_start - n0, 16);

        for (int i = 0; i < 5; i++) begin
            sb.push_back(8'h40 + 8'(i));
            step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        end
        wr_en = 1'b0;
        wait_busy(1'b1, "flush_frame_start");
        sb.delete();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        flush = 1'b0;
        n0 = n_start;
        wait_busy(1'b0, "flush_frame_done");
        repeat (20) @(negedge clk);
        chk("flush_no_launch", n_start - n0, 0);

        sb.push_back(8'h77);
        step(1'b1, 8'h77, 1'b0, 1'b0);
        wr_en = 1'b0;
        wait_busy(1'b1, "reset_frame_start");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx_start", tx_start, 0);
        chk("midrst_tx_data", tx_data, 8'h00);
        chk("midrst_count", count, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sb.push_back(8'h3C);
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("post_rst_count", count, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("post_rst_tx_start", tx_start, 1);
        chk("post_rst_count0", count, 0);
        drain("post_rst_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
